// File: rtl/dp_pkg.sv
// Shared definitions for the datapath arbiter: datapath width, id-width helper, in-flight tag.
package dp_pkg;

  localparam int DP_WIDTH = 32;
  localparam int TAG_ID_W = 3;

  function automatic int clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping; zero latency.
// Pure combinational, no backpressure of its own; o_grant is one-hot or zero.
module rr_select #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
      w_idx = w_sum[PW-1:0];
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dp_arbiter.sv
// Round-robin arbiter sharing one datapath; response appears DP_LATENCY edges after transfer.
// No response backpressure, req_ready is combinational; DP_ARB_STATS_EN adds grant_count.
module dp_arbiter
  import dp_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int WIDTH      = DP_WIDTH,
  parameter int DP_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [WIDTH-1:0]         dp_in1,
  output logic [WIDTH-1:0]         dp_in2,
  output logic                     dp_valid,
  input  logic [WIDTH-1:0]         dp_out
`ifdef DP_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    grant_count
`endif
);

  localparam int PW = clog2(NUM_REQ);

  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      w_gnt_id;
  logic [NUM_REQ-1:0] w_pick;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_xfer;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_data;
  logic [WIDTH-1:0]   r_dp_in1;
  logic [WIDTH-1:0]   r_dp_in2;
  logic               r_dp_valid;
  tag_t               r_tag [DP_LATENCY];
  tag_t               w_last;

  rr_select #(.N(NUM_REQ), .PW(PW)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick)
  );

  // Grants are suppressed during reset so nothing can be issued into a clearing pipe.
  assign w_grant = reset ? '0 : w_pick;
  assign w_xfer  = |w_grant;
  assign w_last  = r_tag[DP_LATENCY-1];

  always_comb begin
    w_gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_gnt_id = PW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_dp_in1    <= '0;
      r_dp_in2    <= '0;
      r_dp_valid  <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      for (int k = 0; k < DP_LATENCY; k++) r_tag[k] <= '0;
    end else begin
      r_dp_valid <= w_xfer;
      if (w_xfer) begin
        r_dp_in1 <= req_a[w_gnt_id*WIDTH +: WIDTH];
        r_dp_in2 <= req_b[w_gnt_id*WIDTH +: WIDTH];
        r_ptr    <= (w_gnt_id == PW'(NUM_REQ-1)) ? '0 : w_gnt_id + PW'(1);
      end
      r_tag[0] <= tag_t'{valid: w_xfer, id: TAG_ID_W'(w_gnt_id)};
      for (int k = 1; k < DP_LATENCY; k++) r_tag[k] <= r_tag[k-1];
      r_rsp_valid <= w_last.valid ? (NUM_REQ'(1) << w_last.id) : '0;
      if (w_last.valid) r_rsp_data <= dp_out;
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign dp_in1    = r_dp_in1;
  assign dp_in2    = r_dp_in2;
  assign dp_valid  = r_dp_valid;

`ifdef DP_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [15:0] r_cnt;
    always_ff @(posedge clk) begin
      if (reset)                              r_cnt <= '0;
      else if (w_grant[i] && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
    assign grant_count[i*16 +: 16] = r_cnt;
  end
`endif

endmodule
